// File: rtl/noc_pkg.sv
// Shared NoC definitions: leaf transmitter FSM states and the default flit width.
package noc_pkg;

    localparam int DIGITS_DEFAULT = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RTZ   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/leaf_tx_bridge.sv
// Clocked valid/ready source to e1of2 four-phase channel bridge with a small inline FIFO.
module leaf_tx_bridge
    import noc_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT,
    parameter int DEPTH  = 2
) (
    input  logic              CLK,
    input  logic              _RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIGITS-1:0] in_data,
    output logic [DIGITS-1:0] out_d0,
    output logic [DIGITS-1:0] out_d1,
    input  logic              out_e,
    output logic              busy,
    output logic [15:0]       tx_count
);

    localparam int           AW   = $clog2(DEPTH);
    localparam logic [AW:0]  FULL = (AW + 1)'(DEPTH);

    logic [DIGITS-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;
    logic              head_avail_q;
    logic              e_s;
    logic              push;
    logic              pop;
    tx_state_t         state;
    logic [15:0]       tx_count_q;

    sync2 u_sync (
        .clk   (CLK),
        .rst_n (_RESET),
        .d     (out_e),
        .q     (e_s)
    );

    assign in_ready = (occ < FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && head_avail_q && e_s && (occ != '0);
    assign busy     = (occ != '0) || (state != IDLE);
    assign tx_count = tx_count_q;

    // NOTE: the storage array has no reset; occupancy and pointers alone decide which entries are live.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // The FSM sees a registered non-empty flag, so a new flit waits one extra edge before launch.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            head_avail_q <= 1'b0;
        end else begin
            head_avail_q <= (occ != '0);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Rails only move on IDLE->DRIVE (data) and DRIVE->RTZ (neutral), always from flops.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state      <= IDLE;
            out_d0     <= '0;
            out_d1     <= '0;
            tx_count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        out_d1 <= mem[rd_ptr];
                        out_d0 <= ~mem[rd_ptr];
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (!e_s) begin
                        out_d0     <= '0;
                        out_d1     <= '0;
                        tx_count_q <= tx_count_q + 16'd1;
                        state      <= RTZ;
                    end
                end
                RTZ: begin
                    if (e_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_tx_bridge.sv
// Scoreboard bench for leaf_tx_bridge: flits queued on acceptance, compared as tokens appear on the rails.
module tb_leaf_tx_bridge;
    import noc_pkg::*;

    localparam int DIGITS = DIGITS_DEFAULT;
    localparam int DEPTH  = 2;

    logic              CLK      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              in_valid = 1'b0;
    logic [DIGITS-1:0] in_data  = '0;
    logic              out_e    = 1'b1;
    logic              in_ready;
    logic              busy;
    logic [DIGITS-1:0] out_d0;
    logic [DIGITS-1:0] out_d1;
    logic [15:0]       tx_count;

    int                checks   = 0;
    int                failures = 0;
    logic [DIGITS-1:0] sb [$];
    logic [15:0]       exp_tx   = 16'd0;

    leaf_tx_bridge #(.DIGITS(DIGITS), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        ._RESET   (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_d0   (out_d0),
        .out_d1   (out_d1),
        .out_e    (out_e),
        .busy     (busy),
        .tx_count (tx_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Offers d for up to budget cycles; records it in the scoreboard when accepted.
    task automatic push_flit(input logic [DIGITS-1:0] d, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            in_data  = d;
            if (in_ready) begin
                @(posedge CLK);
                ok = 1'b1;
                sb.push_back(d);
                @(negedge CLK);
            end
        end
        in_valid = 1'b0;
    endtask

    // Receiver model: waits for a token, checks it against the scoreboard, acknowledges after a delay.
    task automatic recv_token(input int ack_delay, input string tag);
        int                waited;
        logic [DIGITS-1:0] exp;
        waited = 0;
        while ((out_d0 | out_d1) == '0 && waited < 100) begin
            @(negedge CLK);
            waited++;
        end
        checks++;
        if ((out_d0 | out_d1) == '0) begin
            failures++;
            $display("FAIL %s_token_timeout: rails=0 after %0d cycles, required a token", tag, waited);
            return;
        end
        checks++;
        if (((out_d0 ^ out_d1) !== '1) || ((out_d0 & out_d1) !== '0)) begin
            failures++;
            $display("FAIL %s_one_hot: d0=%h d1=%h, required exactly one rail per digit", tag, out_d0, out_d1);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_unexpected_token: d1=%h, required no token", tag, out_d1);
        end else begin
            exp = sb.pop_front();
            if (out_d1 !== exp) begin
                failures++;
                $display("FAIL %s_data: d1=%h, required %h", tag, out_d1, exp);
            end
        end
        repeat (ack_delay) @(negedge CLK);
        out_e  = 1'b0;
        waited = 0;
        while ((out_d0 | out_d1) != '0 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        exp_tx = exp_tx + 16'd1;
        checks++;
        if ((out_d0 | out_d1) !== '0) begin
            failures++;
            $display("FAIL %s_rtz: d0=%h d1=%h, required neutral", tag, out_d0, out_d1);
        end
        checks++;
        if (tx_count !== exp_tx) begin
            failures++;
            $display("FAIL %s_tx_count: got %h, required %h", tag, tx_count, exp_tx);
        end
        out_e = 1'b1;
    endtask

    task automatic settle_idle(input string tag);
        int waited;
        waited = 0;
        while (busy !== 1'b0 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout: busy=%b, required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (out_d0 !== '0 || out_d1 !== '0 || in_ready !== 1'b1 || busy !== 1'b0 || tx_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_during: d0=%h d1=%h rdy=%b busy=%b cnt=%h, required 0/0/1/0/0",
                     out_d0, out_d1, in_ready, busy, tx_count);
        end
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        repeat (4) @(negedge CLK);
        checks++;
        if (out_d0 !== '0 || out_d1 !== '0 || in_ready !== 1'b1 || busy !== 1'b0 || tx_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_after: d0=%h d1=%h rdy=%b busy=%b cnt=%h, required 0/0/1/0/0",
                     out_d0, out_d1, in_ready, busy, tx_count);
        end
    endtask

    task automatic test_single_flit();
        bit ok;
        logic [DIGITS-1:0] exp;
        push_flit(11'h5A3, 4, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_accept: not accepted, required accept");
        end
        checks++;
        if ((out_d0 | out_d1) !== '0) begin
            failures++;
            $display("FAIL single_early_0: d0=%h d1=%h one edge after accept, required neutral", out_d0, out_d1);
        end
        @(negedge CLK);
        checks++;
        if ((out_d0 | out_d1) !== '0) begin
            failures++;
            $display("FAIL single_early_1: d0=%h d1=%h, required neutral", out_d0, out_d1);
        end
        @(negedge CLK);
        checks++;
        if (out_d1 !== 11'h5A3 || out_d0 !== 11'h25C) begin
            failures++;
            $display("FAIL single_rails: d1=%h d0=%h, required 5a3/25c", out_d1, out_d0);
        end
        if (sb.size() > 0) exp = sb.pop_front();
        out_e = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (out_d1 !== 11'h5A3) begin
            failures++;
            $display("FAIL single_hold: d1=%h before sync delay elapsed, required 5a3", out_d1);
        end
        @(negedge CLK);
        exp_tx = exp_tx + 16'd1;
        checks++;
        if ((out_d0 | out_d1) !== '0 || tx_count !== exp_tx) begin
            failures++;
            $display("FAIL single_rtz: d0=%h d1=%h cnt=%h, required 0/0/%h", out_d0, out_d1, tx_count, exp_tx);
        end
        out_e = 1'b1;
        settle_idle("single");
    endtask

    task automatic test_backpressure();
        bit ok;
        @(negedge CLK);
        out_e = 1'b0;
        repeat (4) @(negedge CLK);
        push_flit(11'h123, 1, ok);
        push_flit(11'h456, 1, ok);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready: in_ready=%b after two pushes, required 0", in_ready);
        end
        push_flit(11'h789, 4, ok);
        checks++;
        if (ok) begin
            failures++;
            $display("FAIL bp_third: third flit accepted, required rejection");
        end
        checks++;
        if ((out_d0 | out_d1) !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_rails: d0=%h d1=%h busy=%b, required 0/0/1", out_d0, out_d1, busy);
        end
        out_e = 1'b1;
        recv_token(0, "bp0");
        recv_token(1, "bp1");
        settle_idle("bp");
        repeat (6) @(negedge CLK);
        checks++;
        if ((out_d0 | out_d1) !== '0 || tx_count !== exp_tx) begin
            failures++;
            $display("FAIL bp_extra: d1=%h cnt=%h, required no third token and cnt %h", out_d1, tx_count, exp_tx);
        end
    endtask

    task automatic test_ordered_burst();
        logic [DIGITS-1:0] flits [3];
        flits[0] = 11'h001;
        flits[1] = 11'h7FF;
        flits[2] = 11'h400;
        exp_tx   = 16'd0;
        rst_n    = 1'b0;
        #1 rst_n = 1'b1;
        fork
            begin
                bit ok;
                for (int i = 0; i < 3; i++) begin
                    push_flit(flits[i], 60, ok);
                end
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    recv_token(int'($urandom_range(5, 0)), "burst");
                end
            end
        join
        settle_idle("burst");
        checks++;
        if (tx_count !== 16'd3) begin
            failures++;
            $display("FAIL burst_count: tx_count=%h, required 0003", tx_count);
        end
    endtask

    task automatic test_count_wrap();
        bit ok;
        @(negedge CLK);
        force dut.tx_count_q = 16'hFFFF;
        @(negedge CLK);
        release dut.tx_count_q;
        exp_tx = 16'hFFFF;
        @(negedge CLK);
        push_flit(11'h2C5, 4, ok);
        recv_token(2, "wrap");
        checks++;
        if (tx_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero: tx_count=%h, required 0000", tx_count);
        end
        settle_idle("wrap");
    endtask

    task automatic test_mid_reset();
        bit ok;
        int waited;
        push_flit(11'h2AA, 4, ok);
        waited = 0;
        while ((out_d0 | out_d1) == '0 && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        checks++;
        if (out_d1 !== 11'h2AA) begin
            failures++;
            $display("FAIL mrst_drive: d1=%h, required 2aa before reset", out_d1);
        end
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        exp_tx = 16'd0;
        checks++;
        if ((out_d0 | out_d1) !== '0 || busy !== 1'b0 || in_ready !== 1'b1 || tx_count !== 16'd0) begin
            failures++;
            $display("FAIL mrst_async: d0=%h d1=%h busy=%b rdy=%b cnt=%h, required 0/0/0/1/0",
                     out_d0, out_d1, busy, in_ready, tx_count);
        end
        @(negedge CLK);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if ((out_d0 | out_d1) !== '0 || busy !== 1'b0 || tx_count !== 16'd0) begin
                failures++;
                $display("FAIL mrst_spurious: cycle %0d d1=%h busy=%b cnt=%h, required idle", i, out_d1, busy, tx_count);
            end
        end
    endtask

    task automatic test_glitch();
        logic [15:0] cnt_before;
        cnt_before = tx_count;
        @(negedge CLK);
        #2 out_e = 1'b0;
        #5 out_e = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            checks++;
            if ((out_d0 | out_d1) !== '0 || busy !== 1'b0 || tx_count !== cnt_before) begin
                failures++;
                $display("FAIL glitch: cycle %0d d0=%h d1=%h busy=%b cnt=%h, required quiet idle",
                         i, out_d0, out_d1, busy, tx_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_backpressure();
        test_ordered_burst();
        test_count_wrap();
        test_mid_reset();
        test_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leaf_tx_bridge.md
LEAF_TX_BRIDGE -- requirements
Module: leaf_tx_bridge

Interface
REQ-001 SHALL have parameter DIGITS, default 11, giving the number of 1-of-2 digits per flit: 2 route digits plus 9 payload digits, as consumed by decoder11_leaf.
REQ-002 SHALL have parameter DEPTH, default 2, giving the FIFO entry count; legal values are powers of two, 2..8.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port _RESET, input, 1 bit: the reset; asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the clocked source offers a flit.
REQ-006 SHALL have port in_ready, output, 1 bit: the FIFO can accept a flit.
REQ-007 SHALL have port in_data, input, DIGITS bits: flit value; bit i selects rail 1 (value 1) or rail 0 (value 0) of digit i.
REQ-008 SHALL have port out_d0, output, DIGITS bits: rail-0 wires of the e1of2 channel feeding the router C1in/C2in.
REQ-009 SHALL have port out_d1, output, DIGITS bits: rail-1 wires of that channel.
REQ-010 SHALL have port out_e, input, 1 bit: e1of2 enable from the receiver; 1 = ready for data, 0 = acknowledge. This input is asynchronous to CLK.
REQ-011 SHALL have port busy, output, 1 bit: FIFO non-empty or FSM not in IDLE.
REQ-012 SHALL have port tx_count, output, 16 bits: count of completed four-phase tokens.

Function
REQ-013 SHALL accept a flit on any rising edge where in_valid=1 and in_ready=1.
REQ-014 SHALL drive in_ready = (occupancy < DEPTH) from registered occupancy only, with no combinational path from out_e or pop.
REQ-015 SHALL pass out_e through a 2-flop synchronizer to form e_s before any FSM use.
REQ-016 SHALL implement FSM states IDLE, DRIVE, RTZ.
REQ-017 SHALL, in IDLE with FIFO non-empty and e_s=1, pop the FIFO head, register the rails, and go to DRIVE.
REQ-018 SHALL set the rails as out_d1[i]=data[i] and out_d0[i]=~data[i] when registered in REQ-017.
REQ-019 SHALL, in DRIVE with e_s=0, clear all rails to neutral (all 0), increment tx_count (wrapping 0xFFFF to 0x0000), and go to RTZ.
REQ-020 SHALL, in RTZ with e_s=1, go to IDLE.
REQ-021 SHALL remain in the current state when no transition condition above holds.
REQ-022 SHALL drive every rail from a flop, so that no digit ever has both rails high and rails change only in the IDLE-to-DRIVE and DRIVE-to-RTZ transitions.
REQ-023 SHALL give a latency of rails valid after the 2nd rising edge following the accepting edge, when e_s is already 1 and the FIFO was empty.
REQ-024 SHALL allow a simultaneous push and pop in one edge; occupancy is then unchanged and FIFO order is preserved.
REQ-025 SHALL ignore in_valid while full and leave FIFO contents unchanged.
REQ-026 SHALL ignore a fall of e_s while in IDLE or RTZ.
REQ-027 SHALL ignore a rise of e_s while in DRIVE.

Reset
REQ-028 SHALL, while _RESET=0, immediately set out_d0=0, out_d1=0, FSM=IDLE, occupancy=0, tx_count=0, and both synchronizer flops=0.
REQ-029 SHALL derive in_ready=1 and busy=0 during and after reset from that reset state.
REQ-030 SHALL, when reset is asserted mid-handshake, discard the in-flight flit and drop the rails to neutral without waiting for out_e.
REQ-031 SHALL release reset synchronously to CLK, with deassertion supplied by an external reset synchronizer.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, DRIVE, RTZ) and DIGITS_DEFAULT=11 in shared package noc_pkg.
REQ-033 SHALL implement the synchronizer as sub-module sync2 (1-bit, 2 flops, async active-low reset to 0) and keep the FIFO inline.

Verification
REQ-034 SHALL pass the single-flit case: with out_e held 1, push in_data=0x5A3 -> out_d1=0x5A3 and out_d0=0x25C two edges later; drop out_e -> rails return to 0 within 3 edges and tx_count=1.
REQ-035 SHALL pass the backpressure case: with DEPTH=2 and out_e held 0, push 3 flits -> in_ready=0 after the 2nd push, 3rd flit not accepted, rails stay 0.
REQ-036 SHALL pass the ordered-burst case: push 0x001, 0x7FF, 0x400 with a receiver model acknowledging after random 0-5 cycles -> delivered in that order, each digit one-hot, tx_count=3.
REQ-037 SHALL pass the tx_count wrap case: preload 65535 completed tokens (or force) and complete one more -> tx_count=0x0000.
REQ-038 SHALL pass the mid-handshake reset case: assert _RESET in DRIVE -> rails 0 asynchronously, busy=0, in_ready=1; after release, out_e=1 gives no spurious token.
REQ-039 SHALL pass the glitch case: pulse out_e 1->0->1 for half a cycle while in IDLE with an empty FIFO -> no state change and no rail activity.
